// File: rtl/commit_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_unit
// Purpose  : Multi-lane retire-stream tracer with time-stamped FIFO, watchdog
//            and commit-limit stop, drained one record per cycle.
// Revision : 1.0
// ============================================================================
module commit_trace_unit #(
    parameter int NCOMMIT    = 2,
    parameter int ROB_W      = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int CYC_W      = 48,
    parameter int CNT_W      = 32,
    parameter int WDOG_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_enable,
    input  logic [WDOG_W-1:0]           cfg_wdog_limit,
    input  logic [CNT_W-1:0]            cfg_commit_limit,
    input  logic                        recover_valid,
    input  logic [NCOMMIT-1:0]          commit_valid,
    input  logic [NCOMMIT*32-1:0]       commit_pc,
    input  logic [NCOMMIT*ROB_W-1:0]    commit_rob,
    input  logic [NCOMMIT*5-1:0]        commit_rd,
    input  logic [NCOMMIT*32-1:0]       commit_data,
    output logic                        trc_valid,
    input  logic                        trc_ready,
    output logic [CYC_W-1:0]            trc_cycle,
    output logic [1:0]                  trc_lane,
    output logic [31:0]                 trc_pc,
    output logic [ROB_W-1:0]            trc_rob,
    output logic [4:0]                  trc_rd,
    output logic [31:0]                 trc_data,
    output logic [CYC_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            commit_count,
    output logic [CNT_W-1:0]            drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [1:0]                  state
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = c_ptr_w + 1;
    localparam int c_ln_w   = 3;
    localparam int c_sum_w  = (c_lvl_w > c_ln_w) ? c_lvl_w : c_ln_w;
    localparam int c_cnt_w1 = CNT_W + 1;

    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_run        = 2'd1;
    localparam logic [1:0] c_st_halt_wdog  = 2'd2;
    localparam logic [1:0] c_st_halt_limit = 2'd3;

    // Trace storage, one array per record field
    logic [CYC_W-1:0]   r_mem_cyc  [FIFO_DEPTH];
    logic [1:0]         r_mem_lane [FIFO_DEPTH];
    logic [31:0]        r_mem_pc   [FIFO_DEPTH];
    logic [ROB_W-1:0]   r_mem_rob  [FIFO_DEPTH];
    logic [4:0]         r_mem_rd   [FIFO_DEPTH];
    logic [31:0]        r_mem_data [FIFO_DEPTH];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [1:0]         r_state;
    logic [CYC_W-1:0]   r_cycle;
    logic [CNT_W-1:0]   r_commit;
    logic [CNT_W-1:0]   r_drop;
    logic [WDOG_W-1:0]  r_wdog;

    logic               w_run;
    logic               w_capture;
    logic               w_pop;
    logic [NCOMMIT-1:0] w_acc;
    logic [NCOMMIT-1:0] w_wr_en;
    logic [c_ptr_w-1:0] w_slot [NCOMMIT];
    logic [c_ln_w-1:0]  w_cnt;
    logic [c_ln_w-1:0]  w_accepted;
    logic [c_ln_w-1:0]  w_written;
    logic [c_ln_w-1:0]  w_dropped;
    logic [c_sum_w-1:0] w_free;
    logic [CNT_W:0]     w_commit_sum;
    logic [CNT_W:0]     w_drop_sum;
    logic [CNT_W-1:0]   w_commit_next;
    logic [CNT_W-1:0]   w_drop_next;
    logic               w_limit_hit;
    logic               w_wdog_fire;

    assign w_run     = (r_state == c_st_run);
    assign w_capture = w_run && !recover_valid;
    assign w_acc     = w_capture ? commit_valid : '0;
    // Space is judged on the start-of-cycle level; a same-cycle pop does not help
    assign w_free    = c_sum_w'(FIFO_DEPTH) - c_sum_w'(r_level);
    assign w_pop     = trc_valid && trc_ready;

    // Compact accepted lanes into consecutive slots; lowest lanes win on overflow
    always_comb begin
        w_cnt     = '0;
        w_written = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            w_slot[i]  = r_wr_ptr + c_ptr_w'(w_cnt);
            w_wr_en[i] = w_acc[i] && (c_sum_w'(w_cnt) < w_free);
            if (w_acc[i]) begin
                w_cnt = w_cnt + c_ln_w'(1);
            end
            if (w_wr_en[i]) begin
                w_written = w_written + c_ln_w'(1);
            end
        end
        w_accepted = w_cnt;
        w_dropped  = w_accepted - w_written;
    end

    assign w_commit_sum  = {1'b0, r_commit} + c_cnt_w1'(w_accepted);
    assign w_commit_next = w_commit_sum[CNT_W] ? '1 : w_commit_sum[CNT_W-1:0];
    assign w_drop_sum    = {1'b0, r_drop} + c_cnt_w1'(w_dropped);
    assign w_drop_next   = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

    assign w_limit_hit = (cfg_commit_limit != '0) && (w_commit_next >= cfg_commit_limit);
    assign w_wdog_fire = (cfg_wdog_limit != '0) && (w_accepted == '0)
                         && (r_wdog == cfg_wdog_limit - WDOG_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_state  <= c_st_idle;
            r_cycle  <= '0;
            r_commit <= '0;
            r_drop   <= '0;
            r_wdog   <= '0;
        end else begin
            r_cycle  <= r_cycle + CYC_W'(1);
            r_commit <= w_commit_next;
            r_drop   <= w_drop_next;
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_written);
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_pop);
            r_level  <= r_level + c_lvl_w'(w_written) - c_lvl_w'(w_pop);

            case (r_state)
                c_st_idle: begin
                    if (cfg_enable) begin
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_limit_hit) begin
                        r_state <= c_st_halt_limit;
                    end else if (w_wdog_fire) begin
                        r_state <= c_st_halt_wdog;
                    end
                end
                default: r_state <= r_state;
            endcase

            if (w_run) begin
                if (w_accepted != '0) begin
                    r_wdog <= '0;
                end else if (r_wdog != '1) begin
                    r_wdog <= r_wdog + WDOG_W'(1);
                end
            end else if (r_state == c_st_idle) begin
                r_wdog <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOMMIT; i++) begin
            if (w_wr_en[i]) begin
                r_mem_cyc[w_slot[i]]  <= r_cycle;
                r_mem_lane[w_slot[i]] <= 2'(i);
                r_mem_pc[w_slot[i]]   <= commit_pc[i*32 +: 32];
                r_mem_rob[w_slot[i]]  <= commit_rob[i*ROB_W +: ROB_W];
                r_mem_rd[w_slot[i]]   <= commit_rd[i*5 +: 5];
                r_mem_data[w_slot[i]] <= commit_data[i*32 +: 32];
            end
        end
    end

    // Head fields are forced to zero when empty so unwritten storage never leaks out
    assign trc_valid = (r_level != '0);
    assign trc_cycle = trc_valid ? r_mem_cyc[r_rd_ptr]  : '0;
    assign trc_lane  = trc_valid ? r_mem_lane[r_rd_ptr] : '0;
    assign trc_pc    = trc_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign trc_rob   = trc_valid ? r_mem_rob[r_rd_ptr]  : '0;
    assign trc_rd    = trc_valid ? r_mem_rd[r_rd_ptr]   : '0;
    assign trc_data  = trc_valid ? r_mem_data[r_rd_ptr] : '0;

    assign cycle_count  = r_cycle;
    assign commit_count = r_commit;
    assign drop_count   = r_drop;
    assign fifo_level   = r_level;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_unit
// Purpose  : Table-driven and scoreboard bench for commit_trace_unit.
// Revision : 1.0
// ============================================================================
module tb_commit_trace_unit;

    localparam int NC    = 2;
    localparam int ROBW  = 6;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_enable;
    logic [15:0]        cfg_wdog_limit;
    logic [31:0]        cfg_commit_limit;
    logic               recover_valid;
    logic [NC-1:0]      commit_valid;
    logic [NC*32-1:0]   commit_pc;
    logic [NC*ROBW-1:0] commit_rob;
    logic [NC*5-1:0]    commit_rd;
    logic [NC*32-1:0]   commit_data;
    logic               trc_valid;
    logic               trc_ready;
    logic [47:0]        trc_cycle;
    logic [1:0]         trc_lane;
    logic [31:0]        trc_pc;
    logic [ROBW-1:0]    trc_rob;
    logic [4:0]         trc_rd;
    logic [31:0]        trc_data;
    logic [47:0]        cycle_count;
    logic [31:0]        commit_count;
    logic [31:0]        drop_count;
    logic [4:0]         fifo_level;
    logic [1:0]         state;

    always #5 clk = ~clk;

    commit_trace_unit dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_enable       (cfg_enable),
        .cfg_wdog_limit   (cfg_wdog_limit),
        .cfg_commit_limit (cfg_commit_limit),
        .recover_valid    (recover_valid),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_rob       (commit_rob),
        .commit_rd        (commit_rd),
        .commit_data      (commit_data),
        .trc_valid        (trc_valid),
        .trc_ready        (trc_ready),
        .trc_cycle        (trc_cycle),
        .trc_lane         (trc_lane),
        .trc_pc           (trc_pc),
        .trc_rob          (trc_rob),
        .trc_rd           (trc_rd),
        .trc_data         (trc_data),
        .cycle_count      (cycle_count),
        .commit_count     (commit_count),
        .drop_count       (drop_count),
        .fifo_level       (fifo_level),
        .state            (state)
    );

    typedef struct {
        logic [47:0] cyc;
        logic [1:0]  lane;
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    typedef struct packed {
        logic       en;
        logic [1:0] v;
        logic       rec;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] lvl;
        logic [7:0] cm;
        logic [7:0] dr;
    } vec_t;

    rec_t        sb[$];
    vec_t        tbl [14];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  m_state;
    int          m_wdog;
    longint      m_commit;
    longint      m_drop;
    logic [47:0] m_cyc;
    logic [31:0] g_pc;
    logic [47:0] saved_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: check/pop the head, predict capture, then check counters
    task automatic step(input logic [1:0] v, input logic rec, input logic rdy);
        int          lvl0;
        int          acc;
        int          wr;
        logic        cap;
        logic [31:0] pc;
        rec_t        r;
        commit_valid  = v;
        recover_valid = rec;
        trc_ready     = rdy;
        for (int l = 0; l < NC; l++) begin
            pc = v[l] ? g_pc : $urandom;
            if (v[l]) g_pc = g_pc + 32'd4;
            commit_pc[l*32 +: 32]     = pc;
            commit_rob[l*ROBW +: ROBW] = pc[7:2];
            commit_rd[l*5 +: 5]       = pc[6:2];
            commit_data[l*32 +: 32]   = ~pc;
        end
        lvl0 = sb.size();
        chk("trc_valid", trc_valid, lvl0 != 0);
        if (lvl0 != 0) begin
            r = sb[0];
            chk("trc_pc", trc_pc, r.pc);
            chk("trc_lane", trc_lane, r.lane);
            chk("trc_cycle", trc_cycle, r.cyc);
            chk("trc_rob", trc_rob, r.rob);
            chk("trc_rd", trc_rd, r.rd);
            chk("trc_data", trc_data, r.data);
            if (rdy) r = sb.pop_front();
        end
        cap = (m_state == 2'd1) && !rec;
        acc = 0;
        wr  = 0;
        for (int l = 0; l < NC; l++) begin
            if (cap && v[l]) begin
                acc++;
                if (wr < DEPTH - lvl0) begin
                    r.cyc  = m_cyc;
                    r.lane = 2'(l);
                    r.pc   = commit_pc[l*32 +: 32];
                    r.rob  = commit_rob[l*ROBW +: ROBW];
                    r.rd   = commit_rd[l*5 +: 5];
                    r.data = commit_data[l*32 +: 32];
                    sb.push_back(r);
                    wr++;
                end
            end
        end
        m_commit = m_commit + acc;
        m_drop   = m_drop + (acc - wr);
        case (m_state)
            2'd0: begin
                m_wdog = 0;
                if (cfg_enable) m_state = 2'd1;
            end
            2'd1: begin
                if (cfg_commit_limit != 0 && m_commit >= cfg_commit_limit) m_state = 2'd3;
                else if (cfg_wdog_limit != 0 && acc == 0 && m_wdog == cfg_wdog_limit - 1) m_state = 2'd2;
                if (acc != 0) m_wdog = 0;
                else m_wdog++;
            end
            default: ;
        endcase
        m_cyc = m_cyc + 48'd1;
        @(posedge clk);
        #1;
        chk("fifo_level", fifo_level, sb.size());
        chk("commit_count", commit_count, m_commit);
        chk("drop_count", drop_count, m_drop);
        chk("state", state, m_state);
        chk("cycle_count", cycle_count, m_cyc);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        cfg_enable    = 1'b0;
        commit_valid  = '0;
        recover_valid = 1'b0;
        trc_ready     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_state  = 2'd0;
        m_wdog   = 0;
        m_commit = 0;
        m_drop   = 0;
        m_cyc    = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // en v rec rdy | state level commit drop (after the edge)
        tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b1, 2'd1, 8'd0,  8'd0,  8'd0};
        tbl[1]  = '{1'b1, 2'b11, 1'b0, 1'b1, 2'd1, 8'd2,  8'd2,  8'd0};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd1, 8'd1,  8'd2,  8'd0};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd1, 8'd0,  8'd2,  8'd0};
        tbl[4]  = '{1'b0, 2'b11, 1'b1, 1'b1, 2'd1, 8'd0,  8'd2,  8'd0};
        tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd2,  8'd4,  8'd0};
        tbl[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd4,  8'd6,  8'd0};
        tbl[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd6,  8'd8,  8'd0};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd8,  8'd10, 8'd0};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd10, 8'd12, 8'd0};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd12, 8'd14, 8'd0};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd14, 8'd16, 8'd0};
        tbl[12] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd16, 8'd18, 8'd0};
        tbl[13] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd1, 8'd16, 8'd20, 8'd2};

        rst              = 1'b1;
        cfg_enable       = 1'b0;
        cfg_wdog_limit   = '0;
        cfg_commit_limit = '0;
        recover_valid    = 1'b0;
        commit_valid     = '0;
        commit_pc        = '0;
        commit_rob       = '0;
        commit_rd        = '0;
        commit_data      = '0;
        trc_ready        = 1'b0;
        g_pc             = 32'h0000_0080;
        do_reset();
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", trc_valid, 0);
        chk("rst_state", state, 0);
        chk("rst_commit", commit_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_pc", trc_pc, 0);

        // Commits while IDLE are not captured
        step(2'b11, 1'b0, 1'b1);

        g_pc = 32'h0000_0100;
        for (int i = 0; i < 14; i++) begin
            cfg_enable = tbl[i].en;
            step(tbl[i].v, tbl[i].rec, tbl[i].rdy);
            chk("tbl_state", state, tbl[i].st);
            chk("tbl_level", fifo_level, tbl[i].lvl);
            chk("tbl_commit", commit_count, tbl[i].cm);
            chk("tbl_drop", drop_count, tbl[i].dr);
            if (i == 1) begin
                chk("order_pc0", trc_pc, 32'h100);
                chk("order_lane0", trc_lane, 0);
                saved_cyc = trc_cycle;
            end
            if (i == 2) begin
                chk("order_pc1", trc_pc, 32'h104);
                chk("order_lane1", trc_lane, 1);
                chk("order_same_cycle", trc_cycle, saved_cyc);
            end
        end
        chk("ovf_head_pc", trc_pc, 32'h110);
        for (int i = 0; i < 16; i++) step(2'b00, 1'b0, 1'b1);
        chk("ovf_drained", fifo_level, 0);

        // Watchdog: one commit, a recover cycle, then idle
        do_reset();
        cfg_wdog_limit = 16'd5;
        cfg_enable     = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step((k == 1) ? 2'b11 : 2'b00, k == 1, 1'b0);
            chk("wdog_state", state, (k == 5) ? 2 : 1);
        end
        step(2'b11, 1'b0, 1'b0);
        chk("wdog_halt_commit", commit_count, 1);
        step(2'b00, 1'b0, 1'b1);
        chk("wdog_drain", fifo_level, 0);

        // Commit limit
        do_reset();
        cfg_wdog_limit   = '0;
        cfg_commit_limit = 32'd3;
        cfg_enable       = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("lim_run", state, 1);
        step(2'b11, 1'b0, 1'b0);
        chk("lim_state", state, 3);
        chk("lim_commit", commit_count, 4);
        chk("lim_level", fifo_level, 4);
        step(2'b11, 1'b0, 1'b0);
        chk("lim_halt_commit", commit_count, 4);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1);

        // Limit beats watchdog in the same cycle
        do_reset();
        cfg_commit_limit = '0;
        cfg_enable       = 1'b1;
        step(2'b00, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        cfg_commit_limit = 32'd1;
        cfg_wdog_limit   = 16'd1;
        step(2'b00, 1'b0, 1'b1);
        chk("both_limit_wins", state, 3);

        // Pointer wrap with continuous drain
        do_reset();
        cfg_commit_limit = '0;
        cfg_wdog_limit   = '0;
        cfg_enable       = 1'b1;
        step(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step((i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("wrap_commit", commit_count, 40);
        chk("wrap_drop", drop_count, 0);

        // Reset with a partly full FIFO
        for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 1'b0);
        chk("pre_rst_level", fifo_level, 5);
        rst          = 1'b1;
        commit_valid = '0;
        @(posedge clk);
        #1;
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_valid", trc_valid, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_commit", commit_count, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
